// File: rtl/axi_wr_burst_sched.sv
// Write-burst scheduler: issues fixed-size bursts from a FIFO into a ring buffer, one burst per
// write-master handshake, with a per-burst completion timeout and a level-sensitive abort.
module axi_wr_burst_sched #(
  parameter int unsigned BURST_BYTES = 128,
  parameter int unsigned BURST_BEATS = 16,
  parameter int unsigned LEVEL_W     = 10,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [31:0]        CFG_BASE,
  input  logic [31:0]        CFG_SIZE,
  input  logic               PTR_LOAD,
  input  logic               XFER_START,
  input  logic [15:0]        XFER_BURSTS,
  input  logic               XFER_ABORT,
  output logic               XFER_BUSY,
  output logic               XFER_DONE,
  output logic               XFER_ERR,
  output logic               XFER_ABORTED,
  output logic [15:0]        BURST_CNT,
  output logic [31:0]        WR_PTR,
  input  logic [LEVEL_W-1:0] FIFO_LEVEL,
  output logic               WR_START,
  output logic [31:0]        WR_ADRS,
  output logic [31:0]        WR_LEN,
  input  logic               WR_READY,
  input  logic               WR_DONE
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StIssue,
    StWaitDone,
    StAdvance,
    StFinish
  } state_e;

  localparam logic [LEVEL_W-1:0] BeatsLevel  = LEVEL_W'(BURST_BEATS);
  localparam logic [31:0]        TimeoutLast = 32'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic        wr_start_q;
  logic        xfer_done_q;
  logic        err_q;
  logic        aborted_q;
  logic        abort_seen_q;
  logic [15:0] burst_cnt_q;
  logic [15:0] bursts_q;
  logic [31:0] wr_ptr_q;
  logic [31:0] wr_adrs_q;
  logic [31:0] tmo_q;

  // 33-bit sums so a ring that ends exactly at 2^32 still compares correctly.
  logic [32:0] ptr_sum;
  logic [32:0] ring_end;
  logic        data_ok;

  assign ptr_sum  = {1'b0, wr_ptr_q} + 33'(BURST_BYTES);
  assign ring_end = {1'b0, CFG_BASE} + {1'b0, CFG_SIZE};
  assign data_ok  = WR_READY && (FIFO_LEVEL >= BeatsLevel);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= StIdle;
      wr_start_q   <= 1'b0;
      xfer_done_q  <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      abort_seen_q <= 1'b0;
      burst_cnt_q  <= '0;
      bursts_q     <= '0;
      wr_ptr_q     <= '0;
      wr_adrs_q    <= '0;
      tmo_q        <= '0;
    end else begin
      wr_start_q  <= 1'b0;
      xfer_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A load in the same cycle as a start lands first, so the transfer uses the new base.
          if (PTR_LOAD) begin
            wr_ptr_q <= CFG_BASE;
          end
          if (XFER_START) begin
            bursts_q     <= XFER_BURSTS;
            burst_cnt_q  <= '0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            abort_seen_q <= 1'b0;
            if (XFER_BURSTS == '0) begin
              state_q     <= StFinish;
              xfer_done_q <= 1'b1;
            end else begin
              state_q <= StWaitData;
            end
          end
        end
        StWaitData: begin
          if (XFER_ABORT) begin
            aborted_q   <= 1'b1;
            state_q     <= StFinish;
            xfer_done_q <= 1'b1;
          end else if (data_ok) begin
            state_q    <= StIssue;
            wr_start_q <= 1'b1;
            wr_adrs_q  <= wr_ptr_q;
          end
        end
        StIssue: begin
          state_q <= StWaitDone;
          tmo_q   <= '0;
        end
        StWaitDone: begin
          if (XFER_ABORT) begin
            abort_seen_q <= 1'b1;
          end
          // Timeout wins over a coincident WR_DONE; the pointer is left where it was.
          if (tmo_q == TimeoutLast) begin
            err_q       <= 1'b1;
            state_q     <= StFinish;
            xfer_done_q <= 1'b1;
          end else if (WR_DONE) begin
            state_q <= StAdvance;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        StAdvance: begin
          wr_ptr_q    <= (ptr_sum >= ring_end) ? CFG_BASE : ptr_sum[31:0];
          burst_cnt_q <= burst_cnt_q + 16'd1;
          if ((burst_cnt_q + 16'd1 == bursts_q) || abort_seen_q) begin
            aborted_q   <= abort_seen_q;
            state_q     <= StFinish;
            xfer_done_q <= 1'b1;
          end else begin
            state_q <= StWaitData;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign XFER_BUSY    = (state_q != StIdle);
  assign XFER_DONE    = xfer_done_q;
  assign XFER_ERR     = err_q;
  assign XFER_ABORTED = aborted_q;
  assign BURST_CNT    = burst_cnt_q;
  assign WR_PTR       = wr_ptr_q;
  assign WR_START     = wr_start_q;
  assign WR_ADRS      = wr_adrs_q;
  assign WR_LEN       = 32'(BURST_BYTES);

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Bench for axi_wr_burst_sched: directed scenarios plus randomized transfers checked against a
// ring-pointer reference model and a write-master model that records every burst address.
module tb_axi_wr_burst_sched;

  localparam int unsigned BB  = 128;
  localparam int unsigned TMO = 32;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] CFG_BASE;
  logic [31:0] CFG_SIZE;
  logic        PTR_LOAD;
  logic        XFER_START;
  logic [15:0] XFER_BURSTS;
  logic        XFER_ABORT;
  logic        XFER_BUSY;
  logic        XFER_DONE;
  logic        XFER_ERR;
  logic        XFER_ABORTED;
  logic [15:0] BURST_CNT;
  logic [31:0] WR_PTR;
  logic [9:0]  FIFO_LEVEL;
  logic        WR_START;
  logic [31:0] WR_ADRS;
  logic [31:0] WR_LEN;
  logic        WR_READY;
  logic        WR_DONE;

  int total = 0;
  int bad   = 0;

  // Write-master model controls and the log of addresses it accepted.
  logic [31:0] seen_adrs[$];
  int          lat_min     = 1;
  int          lat_max     = 3;
  bit          master_resp = 1'b1;
  bit          rand_ready  = 1'b0;
  int          pend;

  logic [31:0] m_ptr;

  axi_wr_burst_sched #(
    .BURST_BYTES (BB),
    .BURST_BEATS (16),
    .LEVEL_W     (10),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .CFG_BASE     (CFG_BASE),
    .CFG_SIZE     (CFG_SIZE),
    .PTR_LOAD     (PTR_LOAD),
    .XFER_START   (XFER_START),
    .XFER_BURSTS  (XFER_BURSTS),
    .XFER_ABORT   (XFER_ABORT),
    .XFER_BUSY    (XFER_BUSY),
    .XFER_DONE    (XFER_DONE),
    .XFER_ERR     (XFER_ERR),
    .XFER_ABORTED (XFER_ABORTED),
    .BURST_CNT    (BURST_CNT),
    .WR_PTR       (WR_PTR),
    .FIFO_LEVEL   (FIFO_LEVEL),
    .WR_START     (WR_START),
    .WR_ADRS      (WR_ADRS),
    .WR_LEN       (WR_LEN),
    .WR_READY     (WR_READY),
    .WR_DONE      (WR_DONE)
  );

  always #5 ACLK = ~ACLK;

  // Master model runs on the falling edge so its outputs are stable at the DUT's rising edge.
  initial begin
    WR_READY = 1'b1;
    WR_DONE  = 1'b0;
    pend     = 0;
    forever begin
      @(negedge ACLK);
      WR_DONE = 1'b0;
      if (ARESETN !== 1'b1) begin
        pend     = 0;
        WR_READY = 1'b1;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            WR_DONE  = master_resp;
            WR_READY = 1'b1;
          end
        end else if (rand_ready) begin
          WR_READY = ($urandom_range(0, 3) != 0);
        end
        if (WR_START === 1'b1) begin
          seen_adrs.push_back(WR_ADRS);
          pend     = $urandom_range(lat_min, lat_max);
          WR_READY = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Ring rule: advance by one burst, back to base once the ring end is reached.
  function automatic logic [31:0] next_ptr(input logic [31:0] p, input logic [31:0] base,
                                           input logic [31:0] size);
    longint unsigned s;
    s = 64'(p) + 64'(BB);
    if (s >= 64'(base) + 64'(size)) return base;
    return p + 32'(BB);
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic run_xfer(input int n, input bit load, input int budget,
                          output bit done, output int cycles);
    seen_adrs.delete();
    XFER_BURSTS = 16'(n);
    XFER_START  = 1'b1;
    PTR_LOAD    = load;
    tick();
    XFER_START = 1'b0;
    PTR_LOAD   = 1'b0;
    cycles     = 1;
    done       = (XFER_DONE === 1'b1);
    while (!done && cycles < budget) begin
      tick();
      cycles++;
      done = (XFER_DONE === 1'b1);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b1; CFG_BASE = '0; CFG_SIZE = '0; PTR_LOAD = 1'b0; XFER_START = 1'b0;
    XFER_BURSTS = '0; XFER_ABORT = 1'b0; FIFO_LEVEL = '0;
    #2;
    ARESETN = 1'b0;
    tick();
    tick();
    total++; if (XFER_BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", XFER_BUSY); end
    total++; if (XFER_DONE !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", XFER_DONE); end
    total++; if (XFER_ERR !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", XFER_ERR); end
    total++; if (XFER_ABORTED !== 1'b0) begin bad++; $display("FAIL rst_aborted: got %b want 0", XFER_ABORTED); end
    total++; if (WR_START !== 1'b0) begin bad++; $display("FAIL rst_wr_start: got %b want 0", WR_START); end
    total++; if (BURST_CNT !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %h want 0", BURST_CNT); end
    total++; if (WR_PTR !== 32'd0) begin bad++; $display("FAIL rst_ptr: got %h want 0", WR_PTR); end
    total++; if (WR_ADRS !== 32'd0) begin bad++; $display("FAIL rst_adrs: got %h want 0", WR_ADRS); end
    total++; if (WR_LEN !== 32'(BB)) begin bad++; $display("FAIL wr_len: got %h want %h", WR_LEN, 32'(BB)); end
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    bit done; int cyc; logic [31:0] exp;
    CFG_BASE = 32'h1000; CFG_SIZE = 32'h400; FIFO_LEVEL = 10'd16;
    PTR_LOAD = 1'b1;
    tick();
    PTR_LOAD = 1'b0;
    m_ptr = CFG_BASE;
    total++; if (WR_PTR !== 32'h1000) begin bad++; $display("FAIL load_ptr: got %h want %h", WR_PTR, 32'h1000); end
    run_xfer(3, 1'b0, 200, done, cyc);
    total++; if (!done) begin bad++; $display("FAIL normal_done: got no XFER_DONE want pulse within 200"); end
    total++; if (seen_adrs.size() != 3) begin bad++; $display("FAIL normal_nbursts: got %0d want 3", seen_adrs.size()); end
    exp = m_ptr;
    for (int i = 0; i < 3 && i < seen_adrs.size(); i++) begin
      total++;
      if (seen_adrs[i] !== exp) begin bad++; $display("FAIL normal_adrs%0d: got %h want %h", i, seen_adrs[i], exp); end
      exp = next_ptr(exp, CFG_BASE, CFG_SIZE);
    end
    m_ptr = exp;
    total++; if (BURST_CNT !== 16'd3) begin bad++; $display("FAIL normal_cnt: got %0d want 3", BURST_CNT); end
    total++; if (WR_PTR !== 32'h1180) begin bad++; $display("FAIL normal_ptr: got %h want %h", WR_PTR, 32'h1180); end
    total++; if (XFER_BUSY !== 1'b1) begin bad++; $display("FAIL normal_busy_fin: got %b want 1", XFER_BUSY); end
    tick();
    total++; if (XFER_BUSY !== 1'b0) begin bad++; $display("FAIL normal_busy_idle: got %b want 0", XFER_BUSY); end
    total++; if (XFER_DONE !== 1'b0) begin bad++; $display("FAIL normal_done_1cyc: got %b want 0", XFER_DONE); end
  endtask

  task automatic test_wrap();
    bit done; int cyc; logic [31:0] exp;
    run_xfer(4, 1'b0, 300, done, cyc);
    m_ptr = next_ptr(next_ptr(next_ptr(next_ptr(m_ptr, CFG_BASE, CFG_SIZE), CFG_BASE, CFG_SIZE),
                              CFG_BASE, CFG_SIZE), CFG_BASE, CFG_SIZE);
    total++; if (WR_PTR !== m_ptr) begin bad++; $display("FAIL wrap_pre_ptr: got %h want %h", WR_PTR, m_ptr); end
    tick();
    run_xfer(2, 1'b0, 200, done, cyc);
    total++; if (!done) begin bad++; $display("FAIL wrap_done: got no XFER_DONE want pulse"); end
    total++; if (seen_adrs.size() != 2) begin bad++; $display("FAIL wrap_nbursts: got %0d want 2", seen_adrs.size()); end
    exp = m_ptr;
    for (int i = 0; i < 2 && i < seen_adrs.size(); i++) begin
      total++;
      if (seen_adrs[i] !== exp) begin bad++; $display("FAIL wrap_adrs%0d: got %h want %h", i, seen_adrs[i], exp); end
      exp = next_ptr(exp, CFG_BASE, CFG_SIZE);
    end
    m_ptr = exp;
    total++; if (WR_PTR !== 32'h1080) begin bad++; $display("FAIL wrap_ptr: got %h want %h", WR_PTR, 32'h1080); end
    tick();
  endtask

  task automatic test_starvation();
    int starts; bit seen; int cyc;
    seen_adrs.delete();
    FIFO_LEVEL  = 10'd15;
    XFER_BURSTS = 16'd1;
    XFER_START  = 1'b1;
    tick();
    XFER_START = 1'b0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (WR_START === 1'b1) starts++;
    end
    total++; if (starts != 0) begin bad++; $display("FAIL starve_no_start: got %0d WR_START want 0", starts); end
    total++; if (XFER_BUSY !== 1'b1) begin bad++; $display("FAIL starve_busy: got %b want 1", XFER_BUSY); end
    FIFO_LEVEL = 10'd16;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      if (WR_START === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL starve_start: got no WR_START want one within 2 cycles"); end
    total++; if (WR_ADRS !== m_ptr) begin bad++; $display("FAIL starve_adrs: got %h want %h", WR_ADRS, m_ptr); end
    cyc = 0;
    while (XFER_DONE !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    total++; if (XFER_DONE !== 1'b1) begin bad++; $display("FAIL starve_done: got no XFER_DONE want pulse"); end
    m_ptr = next_ptr(m_ptr, CFG_BASE, CFG_SIZE);
    total++; if (BURST_CNT !== 16'd1) begin bad++; $display("FAIL starve_cnt: got %0d want 1", BURST_CNT); end
    tick();
  endtask

  task automatic test_zero();
    bit done; int cyc;
    run_xfer(0, 1'b0, 2, done, cyc);
    total++; if (!done) begin bad++; $display("FAIL zero_done: got no XFER_DONE want pulse within 2"); end
    total++; if (seen_adrs.size() != 0) begin bad++; $display("FAIL zero_no_start: got %0d bursts want 0", seen_adrs.size()); end
    total++; if (WR_PTR !== m_ptr) begin bad++; $display("FAIL zero_ptr: got %h want %h", WR_PTR, m_ptr); end
    total++; if (BURST_CNT !== 16'd0) begin bad++; $display("FAIL zero_cnt: got %0d want 0", BURST_CNT); end
    tick();
  endtask

  task automatic test_timeout();
    bit done; int cyc;
    master_resp = 1'b0;
    run_xfer(1, 1'b0, 100, done, cyc);
    total++; if (!done) begin bad++; $display("FAIL tmo_done: got no XFER_DONE want pulse"); end
    total++; if (cyc < int'(TMO) + 2 || cyc > int'(TMO) + 4) begin
      bad++; $display("FAIL tmo_latency: got %0d cycles want %0d..%0d", cyc, TMO + 2, TMO + 4);
    end
    total++; if (XFER_ERR !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", XFER_ERR); end
    total++; if (WR_PTR !== m_ptr) begin bad++; $display("FAIL tmo_ptr: got %h want %h", WR_PTR, m_ptr); end
    total++; if (BURST_CNT !== 16'd0) begin bad++; $display("FAIL tmo_cnt: got %0d want 0", BURST_CNT); end
    total++; if (seen_adrs.size() != 1) begin bad++; $display("FAIL tmo_nbursts: got %0d want 1", seen_adrs.size()); end
    master_resp = 1'b1;
    tick();
    tick();
    total++; if (XFER_ERR !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky: got %b want 1", XFER_ERR); end
  endtask

  task automatic test_abort();
    bit seen; bit done; int cyc;
    lat_min = 6; lat_max = 6;
    seen_adrs.delete();
    XFER_BURSTS = 16'd4;
    XFER_START  = 1'b1;
    tick();
    XFER_START = 1'b0;
    total++; if (XFER_ERR !== 1'b0) begin bad++; $display("FAIL abort_err_clr: got %b want 0", XFER_ERR); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (WR_START === 1'b1) seen = 1'b1;
    end
    XFER_ABORT = 1'b1;
    cyc = 0;
    while (XFER_DONE !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    total++; if (XFER_DONE !== 1'b1) begin bad++; $display("FAIL abort_done: got no XFER_DONE want pulse"); end
    total++; if (XFER_ABORTED !== 1'b1) begin bad++; $display("FAIL abort_flag: got %b want 1", XFER_ABORTED); end
    total++; if (BURST_CNT !== 16'd1) begin bad++; $display("FAIL abort_cnt: got %0d want 1", BURST_CNT); end
    total++; if (seen_adrs.size() != 1) begin bad++; $display("FAIL abort_nbursts: got %0d want 1", seen_adrs.size()); end
    m_ptr = next_ptr(m_ptr, CFG_BASE, CFG_SIZE);
    total++; if (WR_PTR !== m_ptr) begin bad++; $display("FAIL abort_ptr: got %h want %h", WR_PTR, m_ptr); end
    XFER_ABORT = 1'b0;
    tick();
    // Abort while starved for data: no burst at all.
    FIFO_LEVEL = 10'd0;
    XFER_BURSTS = 16'd2;
    XFER_START  = 1'b1;
    tick();
    XFER_START = 1'b0;
    tick();
    tick();
    XFER_ABORT = 1'b1;
    cyc = 0;
    while (XFER_DONE !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    total++; if (XFER_DONE !== 1'b1) begin bad++; $display("FAIL abort_wd_done: got no XFER_DONE want pulse"); end
    total++; if (XFER_ABORTED !== 1'b1) begin bad++; $display("FAIL abort_wd_flag: got %b want 1", XFER_ABORTED); end
    total++; if (BURST_CNT !== 16'd0) begin bad++; $display("FAIL abort_wd_cnt: got %0d want 0", BURST_CNT); end
    XFER_ABORT = 1'b0;
    FIFO_LEVEL = 10'd16;
    lat_min = 1; lat_max = 3;
    tick();
    done = 1'b0;
  endtask

  task automatic test_random();
    bit done; int cyc; int n; bit load; logic [31:0] exp;
    rand_ready = 1'b1;
    lat_min = 1; lat_max = 4;
    for (int it = 0; it < 8; it++) begin
      load = (it % 2 == 0);
      if (it == 0) begin
        CFG_BASE = 32'hFFFF_FC00;
        CFG_SIZE = 32'h400;
      end else if (load) begin
        CFG_BASE = $urandom_range(0, 32'h7FFF_FFFF) & ~32'h7F;
        CFG_SIZE = 32'(BB) * $urandom_range(1, 8);
      end
      if (load) m_ptr = CFG_BASE;
      n = $urandom_range(1, 12);
      FIFO_LEVEL = 10'($urandom_range(16, 1023));
      run_xfer(n, load, 400, done, cyc);
      total++; if (!done) begin bad++; $display("FAIL rnd%0d_done: got no XFER_DONE want pulse", it); end
      total++; if (seen_adrs.size() != n) begin bad++; $display("FAIL rnd%0d_nbursts: got %0d want %0d", it, seen_adrs.size(), n); end
      exp = m_ptr;
      for (int i = 0; i < n && i < seen_adrs.size(); i++) begin
        total++;
        if (seen_adrs[i] !== exp) begin bad++; $display("FAIL rnd%0d_adrs%0d: got %h want %h", it, i, seen_adrs[i], exp); end
        exp = next_ptr(exp, CFG_BASE, CFG_SIZE);
      end
      m_ptr = exp;
      total++; if (BURST_CNT !== 16'(n)) begin bad++; $display("FAIL rnd%0d_cnt: got %0d want %0d", it, BURST_CNT, n); end
      total++; if (WR_PTR !== m_ptr) begin bad++; $display("FAIL rnd%0d_ptr: got %h want %h", it, WR_PTR, m_ptr); end
      total++; if ({XFER_ERR, XFER_ABORTED} !== 2'b00) begin bad++; $display("FAIL rnd%0d_flags: got %b want 00", it, {XFER_ERR, XFER_ABORTED}); end
      tick();
    end
    rand_ready = 1'b0;
    FIFO_LEVEL = 10'd16;
  endtask

  task automatic test_reset_mid();
    bit seen; int dones;
    lat_min = 10; lat_max = 10;
    XFER_BURSTS = 16'd3;
    XFER_START  = 1'b1;
    tick();
    XFER_START = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (WR_START === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rstmid_start: got no WR_START want burst"); end
    tick();
    #2;
    ARESETN = 1'b0;
    #1;
    total++;
    if ({XFER_BUSY, XFER_DONE, XFER_ERR, XFER_ABORTED, WR_START, BURST_CNT, WR_PTR, WR_ADRS} !== '0) begin
      bad++;
      $display("FAIL rstmid_async: got busy=%b done=%b err=%b abt=%b start=%b cnt=%h ptr=%h adrs=%h want all 0",
               XFER_BUSY, XFER_DONE, XFER_ERR, XFER_ABORTED, WR_START, BURST_CNT, WR_PTR, WR_ADRS);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (XFER_DONE === 1'b1) dones++;
    end
    ARESETN = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (XFER_DONE === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); end
    total++; if (XFER_BUSY !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got %b want 0", XFER_BUSY); end
    total++; if (WR_PTR !== 32'd0) begin bad++; $display("FAIL rstmid_ptr: got %h want 0", WR_PTR); end
    lat_min = 1; lat_max = 3;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_wrap();
    test_starvation();
    test_zero();
    test_timeout();
    test_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
